// File: rtl/proc_defs.sv
// proc_defs: opcodes, timestep encoding and IR field positions shared by the processor blocks.
package proc_defs;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_SEQ = 3'b100;
    localparam logic [2:0] OP_SGT = 3'b101;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } tstep_t;

    localparam int OP_MSB = 15;
    localparam int OP_LSB = 13;
    localparam int X_MSB  = 12;
    localparam int X_LSB  = 10;
    localparam int Y_MSB  = 9;
    localparam int Y_LSB  = 7;

endpackage

// File: rtl/dec3to8.sv
// dec3to8: 3-bit index to one-hot-8 decoder, all zeros when disabled.
module dec3to8 (
    input  logic       en,
    input  logic [2:0] sel,
    output logic [7:0] y
);

    assign y = en ? (8'b1 << sel) : 8'b0;

endmodule

// File: rtl/proc_control.sv
// proc_control: multicycle control FSM sequencing each instruction over timesteps T0-T3.
module proc_control
    import proc_defs::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  run,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  ir_in,
    output logic [7:0]            r_in,
    output logic [7:0]            r_out,
    output logic                  a_in,
    output logic                  g_in,
    output logic                  g_out,
    output logic                  din_out,
    output logic                  soma,
    output logic                  add_sub,
    output logic                  comparacao,
    output logic                  maior_menor,
    output logic                  done
);

    tstep_t                state, next_state;
    logic [DATA_WIDTH-1:0] ir;
    logic [2:0]            op, x, y;
    logic                  is_alu, t1, t2, t3;
    logic                  r_in_en, r_out_en, r_out_y;
    logic                  ir_unused;

    assign op        = ir[OP_MSB:OP_LSB];
    assign x         = ir[X_MSB:X_LSB];
    assign y         = ir[Y_MSB:Y_LSB];
    assign ir_unused = ^ir[Y_LSB-1:0];
    assign is_alu    = (op >= OP_ADD) && (op <= OP_SGT);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= T0;
            ir    <= '0;
        end else begin
            state <= next_state;
            if (state == T0 && run)
                ir <= din;
        end
    end

    always_comb begin
        next_state = (state == T0) ? (run ? T1 : T0) :
                     (state == T1) ? (is_alu ? T2 : T0) :
                     (state == T2) ? T3 : T0;
    end

    assign t1 = (state == T1);
    assign t2 = (state == T2);
    assign t3 = (state == T3);

    always_comb begin
        // ir_in is gated by resetn so a held run cannot leak through while reset is asserted
        ir_in       = resetn && (state == T0) && run;
        r_in_en     = (t1 && (op == OP_MV || op == OP_MVI)) || t3;
        r_out_en    = (t1 && (op == OP_MV || is_alu)) || t2;
        r_out_y     = (t1 && op == OP_MV) || t2;
        a_in        = t1 && is_alu;
        g_in        = t2;
        g_out       = t3;
        din_out     = t1 && (op == OP_MVI);
        soma        = t2 && (op == OP_ADD || op == OP_SUB);
        add_sub     = t2 && (op == OP_SUB);
        comparacao  = t2 && (op == OP_SEQ);
        maior_menor = t2 && (op == OP_SGT);
        done        = (t1 && !is_alu) || t3;
    end

    dec3to8 u_dec_in (
        .en  (r_in_en),
        .sel (x),
        .y   (r_in)
    );

    dec3to8 u_dec_out (
        .en  (r_out_en),
        .sel (r_out_y ? y : x),
        .y   (r_out)
    );

endmodule

// File: doc/proc_control.md
# proc_control

Multicycle control unit for the 16-bit datapath. Fetches an instruction word from `din`, sequences it over timesteps T0–T3, and drives the register-file enables, the bus-driver selects and the arithmetic unit's operation lines (`soma`, `add_sub`, `comparacao`, `maior_menor`). It sits beside the register file, A/G registers and the add/sub/compare unit, and issues every operation request that unit executes.

## Interface
Parameters:
- `DATA_WIDTH`, 16: width of `din` and of the internal instruction register (IR).

Ports:
- `clock` in 1: single clock; all state changes on the rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `run` in 1: start request; sampled only in T0.
- `din` in DATA_WIDTH: instruction word in T0; immediate operand for `mvi` in T1.
- `ir_in` out 1: IR load strobe; IR is internal.
- `r_in` out 8: one-hot register-file write enable.
- `r_out` out 8: one-hot register-file bus-driver select.
- `a_in` out 1: load A from the bus.
- `g_in` out 1: load G from the arithmetic unit output.
- `g_out` out 1: G drives the bus.
- `din_out` out 1: `din` drives the bus.
- `soma`, `add_sub`, `comparacao`, `maior_menor` out 1 each: arithmetic-unit operation lines.
- `done` out 1: one-cycle pulse in the final timestep of each instruction.

## Operation
- Instruction format: `op` = IR[15:13], `x` = IR[12:10], `y` = IR[9:7]. IR[6:0] is ignored.
- Opcodes:
  - `000` mv: Rx←Ry
  - `001` mvi: Rx←din
  - `010` add: Rx←Rx+Ry
  - `011` sub: Rx←Rx−Ry
  - `100` seq: Rx←(Rx==Ry)
  - `101` sgt: Rx←(Rx>Ry), unsigned
  - `110`, `111`: reserved. Executed as NOP.
- T0: if `run`=1, `ir_in`=1, IR←din, go to T1. Otherwise stay in T0 with all outputs 0.
- T1:
  - mv: `r_out[y]`, `r_in[x]`, `done`, go to T0.
  - mvi: `din_out`, `r_in[x]`, `done`, go to T0.
  - add/sub/seq/sgt: `r_out[x]`, `a_in`, go to T2.
  - reserved: `done` only, go to T0.
- T2: `r_out[y]`, `g_in`, plus the operation lines, go to T3.
  - add: `soma`=1, `add_sub`=0.
  - sub: `soma`=1, `add_sub`=1.
  - seq: `comparacao`=1.
  - sgt: `maior_menor`=1.
- T3: `g_out`, `r_in[x]`, `done`, go to T0.
- `soma`, `comparacao` and `maior_menor` are mutually exclusive. All three are 0 outside T2.
- `add_sub` is 0 whenever `soma`=0.
- At most one bus driver is active per cycle, counting all bits of `r_out`, `g_out` and `din_out`.
- `r_in` is 0 or one-hot.
- `x`==`y` is legal and needs no special handling.

## Timing
- Reset: `resetn`=0 forces T0 and IR=0, and drives every output to 0 immediately (asynchronous).
- Reset asserted mid-instruction: the instruction is abandoned and no further `r_in` pulse is issued. Execution resumes only when `run`=1 in T0 after reset is released.
- Outputs are a combinational decode of (timestep, IR); there are no registered outputs.
  - In T0, `ir_in` follows `run` combinationally.
  - In T1–T3, outputs decode the IR loaded at the end of T0.
- Latency, `run` sampled to `done`:
  - mv, mvi, reserved: 2 cycles (T0, T1).
  - add, sub, seq, sgt: 4 cycles (T0–T3).
- `run` is ignored in T1–T3. If `run` is held high, the next instruction fetch begins in the cycle after `done`.
- For `mvi`, `din` must hold the immediate during T1.

## Structure
- Shared package `proc_defs` holds:
  - the opcode constants (`OP_MV`, `OP_MVI`, `OP_ADD`, `OP_SUB`, `OP_SEQ`, `OP_SGT`);
  - the timestep encoding (`T0`–`T3`, 2 bits);
  - the IR field bit positions.
- The datapath and the arithmetic unit use the same package.
- Sub-module `dec3to8`: 3-bit to one-hot-8 decoder with an enable input. Instantiate one for `r_in[x]`, and one for `r_out` selecting between `x` and `y` by timestep.

## Test plan
- Reset: hold `resetn`=0 for 3 cycles with `run`=1 → all outputs 0, state T0. Release reset → `ir_in`=1 in the first cycle.
- mvi R3: `din`=0x2C00 in T0, then `din`=0x00AB in T1 → T1 shows `din_out`=1, `r_in`=0x08, `done`=1. Next cycle is T0.
- add R1,R2: `din`=0x4500 →
  - T1: `r_out`=0x02, `a_in`.
  - T2: `r_out`=0x04, `g_in`, `soma`=1, `add_sub`=0.
  - T3: `g_out`, `r_in`=0x02, `done`.
- sub R4,R5 (`din`=0x7280) and sgt R0,R7 (`din`=0xA380):
  - sub T2: `soma`=1, `add_sub`=1.
  - sgt T2: `maior_menor`=1, `soma`=0, `comparacao`=0.
  - sgt T3: `r_in`=0x01.
- mv R6,R0 (`din`=0x1800), then reserved 0xC000, with `run` held high → mv T1: `r_out`=0x01, `r_in`=0x40, `done`. Reserved T1: only `done`=1.
- Reset mid-instruction: assert `resetn`=0 during T2 of add → outputs 0 at once. T3 never occurs and there is no `r_in` pulse. After release, with `run`=0, the block stays idle.
